// File: rtl/ptc_dt_pkg.sv
// Shared types and constants for the complementary dead-time generator.
// State encoding is one-hot; the *_IDX constants name the bit of each state.
package ptc_dt_pkg;

   localparam int DT_W_DEF = 8;

   localparam int ST_N           = 6;
   localparam int ST_IDLE_IDX    = 0;
   localparam int ST_LO_IDX      = 1;
   localparam int ST_DT_RISE_IDX = 2;
   localparam int ST_HI_IDX      = 3;
   localparam int ST_DT_FALL_IDX = 4;
   localparam int ST_FAULT_IDX   = 5;

   typedef enum logic [ST_N-1:0] {
      ST_IDLE    = 6'b000001,
      ST_LO      = 6'b000010,
      ST_DT_RISE = 6'b000100,
      ST_HI      = 6'b001000,
      ST_DT_FALL = 6'b010000,
      ST_FAULT   = 6'b100000
   } ptc_dt_state_t;

endpackage

// File: rtl/ptc_sync2.sv
// Generic two-flop synchroniser for asynchronous level inputs.
// Both stages clear to 0 on the asynchronous active-low reset.
module ptc_sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/ptc_deadtime_gen.sv
// Complementary high/low gate-drive generator with per-edge dead time and sticky fault.
// Optional PTC_DT_POLARITY_EN adds out_pol[1:0] to set the inactive level of each output.
import ptc_dt_pkg::*;

module ptc_deadtime_gen #(
   parameter int DT_W = DT_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pwm_i,
   input  logic            en,
   input  logic [DT_W-1:0] dt_rise,
   input  logic [DT_W-1:0] dt_fall,
   input  logic            fault_i,
   input  logic            fault_clr,
   output logic            out_hi,
   output logic            out_lo,
   output logic            fault_sts,
   output logic            dt_busy
`ifdef PTC_DT_POLARITY_EN
   ,
   input  logic [1:0]      out_pol
`endif
);

   ptc_dt_state_t   r_state;
   ptc_dt_state_t   w_state_next;
   logic [DT_W-1:0] r_cnt;
   logic [DT_W-1:0] w_cnt_next;
   logic            r_pwm_q;
   logic            w_fault_s;
   logic            w_hi_dec;
   logic            w_lo_dec;

   ptc_sync2 #(.W(1)) u_fault_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (fault_i),
      .o_q   (w_fault_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_pwm_q <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_pwm_q <= pwm_i;
      end
   end

   // The counter is loaded only on entry to a dead-time state and never decrements past 0.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      if (w_fault_s) begin
         w_state_next = ST_FAULT;
      end else if (!en && (r_state != ST_FAULT)) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (en) w_state_next = ST_LO;
            end
            ST_LO: begin
               if (r_pwm_q) begin
                  if (dt_rise == '0) begin
                     w_state_next = ST_HI;
                  end else begin
                     w_state_next = ST_DT_RISE;
                     w_cnt_next   = dt_rise - DT_W'(1);
                  end
               end
            end
            ST_DT_RISE: begin
               if (!r_pwm_q)          w_state_next = ST_LO;
               else if (r_cnt == '0)  w_state_next = ST_HI;
               else                   w_cnt_next   = r_cnt - DT_W'(1);
            end
            ST_HI: begin
               if (!r_pwm_q) begin
                  if (dt_fall == '0) begin
                     w_state_next = ST_LO;
                  end else begin
                     w_state_next = ST_DT_FALL;
                     w_cnt_next   = dt_fall - DT_W'(1);
                  end
               end
            end
            ST_DT_FALL: begin
               if (r_pwm_q)           w_state_next = ST_HI;
               else if (r_cnt == '0)  w_state_next = ST_LO;
               else                   w_cnt_next   = r_cnt - DT_W'(1);
            end
            ST_FAULT: begin
               if (fault_clr) w_state_next = ST_IDLE;
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   assign w_hi_dec  = r_state[ST_HI_IDX];
   assign w_lo_dec  = r_state[ST_LO_IDX];
   assign dt_busy   = r_state[ST_DT_RISE_IDX] | r_state[ST_DT_FALL_IDX];
   assign fault_sts = r_state[ST_FAULT_IDX];

`ifdef PTC_DT_POLARITY_EN
   assign out_hi = w_hi_dec ^ out_pol[1];
   assign out_lo = w_lo_dec ^ out_pol[0];
`else
   assign out_hi = w_hi_dec;
   assign out_lo = w_lo_dec;
`endif

endmodule

// File: tb/tb_ptc_deadtime_gen.sv
// Scoreboard bench for ptc_deadtime_gen: expected output vectors {hi,lo,busy,fault}
// are derived from the edge-latency rules and queued as each stimulus cycle is driven.
module tb_ptc_deadtime_gen;
   import ptc_dt_pkg::*;

   localparam int DT_W = 8;

   localparam logic [3:0] V_IDLE = 4'b0000;
   localparam logic [3:0] V_LO   = 4'b0100;
   localparam logic [3:0] V_HI   = 4'b1000;
   localparam logic [3:0] V_DT   = 4'b0010;
   localparam logic [3:0] V_FLT  = 4'b0001;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            pwm_i = 1'b0;
   logic            en = 1'b0;
   logic [DT_W-1:0] dt_rise = '0;
   logic [DT_W-1:0] dt_fall = '0;
   logic            fault_i = 1'b0;
   logic            fault_clr = 1'b0;
   logic            out_hi;
   logic            out_lo;
   logic            fault_sts;
   logic            dt_busy;
   logic [1:0]      pol;
   logic [3:0]      obs;

   int              tests_run = 0;
   int              tests_failed = 0;
   logic [3:0]      exp_q[$];

`ifdef PTC_DT_POLARITY_EN
   logic [1:0] out_pol;
   initial pol = 2'b11;
   assign out_pol = pol;
`else
   initial pol = 2'b00;
`endif

   ptc_deadtime_gen #(.DT_W(DT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pwm_i     (pwm_i),
      .en        (en),
      .dt_rise   (dt_rise),
      .dt_fall   (dt_fall),
      .fault_i   (fault_i),
      .fault_clr (fault_clr),
      .out_hi    (out_hi),
      .out_lo    (out_lo),
      .fault_sts (fault_sts),
      .dt_busy   (dt_busy)
`ifdef PTC_DT_POLARITY_EN
      ,
      .out_pol   (out_pol)
`endif
   );

   always #5 clk = ~clk;

   assign obs = {out_hi, out_lo, dt_busy, fault_sts};

   function automatic logic [3:0] pv(input logic [3:0] v);
      return {v[3] ^ pol[1], v[2] ^ pol[0], v[1:0]};
   endfunction

   task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s got=%b exp=%b (hi,lo,busy,flt)", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = %b", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_tick(input logic [3:0] e, input string tag);
      logic [3:0] want;
      exp_q.push_back(pv(e));
      tick();
      want = exp_q.pop_front();
      check_val(tag, obs, want);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] e;
      int m;

      #12;
      check_val("reset", obs, pv(V_IDLE));
      @(negedge clk);
      rst_n   = 1'b1;
      en      = 1'b1;
      dt_rise = 8'd3;
      dt_fall = 8'd5;
      push_tick(V_LO, "en_to_lo");

      // 20-high / 20-low square wave; m is the edge offset from the rising input edge.
      for (int n = 0; n < 80; n++) begin
         pwm_i = ((n % 40) < 20);
         m = n % 40;
         if (m == 0 || m >= 26) e = V_LO;
         else if (m <= 3)       e = V_DT;
         else if (m <= 20)      e = V_HI;
         else                   e = V_DT;
         push_tick(e, $sformatf("sq%0d", n));
      end

      // Pulse shorter than the rising dead time is swallowed.
      dt_rise = 8'd4;
      for (int n = 0; n < 8; n++) begin
         pwm_i = (n < 2);
         e = (n == 1 || n == 2) ? V_DT : V_LO;
         push_tick(e, $sformatf("short%0d", n));
      end

      // Zero dead time: direct hand-over on one edge.
      dt_rise = 8'd0;
      dt_fall = 8'd0;
      for (int n = 0; n < 20; n++) begin
         pwm_i = ((n % 10) < 5);
         m = n % 10;
         e = (m >= 1 && m <= 5) ? V_HI : V_LO;
         push_tick(e, $sformatf("dt0_%0d", n));
      end

      // Fault: single-cycle pulse while in HI.
      pwm_i = 1'b1;
      push_tick(V_LO, "f_pre0");
      push_tick(V_HI, "f_pre1");
      fault_i = 1'b1;
      push_tick(V_HI, "f_k");
      fault_i = 1'b0;
      push_tick(V_HI, "f_k1");
      tick();
      push_tick(V_FLT, "f_k3");
      fault_i = 1'b1;
      tick();
      tick();
      tick();
      fault_clr = 1'b1;
      push_tick(V_FLT, "f_clr_ignored");
      fault_clr = 1'b0;
      fault_i   = 1'b0;
      pwm_i     = 1'b0;
      tick();
      tick();
      tick();
      push_tick(V_FLT, "f_sticky");
      fault_clr = 1'b1;
      push_tick(V_IDLE, "f_clr_idle");
      fault_clr = 1'b0;
      push_tick(V_LO, "f_relo");

      // en dropped while the rising dead-time counter reads 2.
      dt_rise = 8'd5;
      pwm_i   = 1'b1;
      push_tick(V_LO, "en_k");
      push_tick(V_DT, "en_cnt4");
      push_tick(V_DT, "en_cnt3");
      push_tick(V_DT, "en_cnt2");
      en = 1'b0;
      push_tick(V_IDLE, "en_drop");
      en = 1'b1;
      push_tick(V_LO, "en_back");

      // Asynchronous reset in HI, between clock edges.
      dt_rise = 8'd0;
      push_tick(V_HI, "r_hi0");
      push_tick(V_HI, "r_hi1");
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_rst", obs, pv(V_IDLE));
      @(negedge clk);
      rst_n = 1'b1;

      check_val("queue_empty", 4'(exp_q.size()), 4'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
